// File: rtl/fpu_resp_buffer_if.sv
// Handshake and result bus between the interconnect, the shared FPU wrapper
// and the credit-gated response buffer.
interface fpu_resp_buffer_if #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Request handshake (payload bypasses the buffer)
    logic                       req_i;
    logic                       gnt_o;
    logic                       fpu_req_o;
    logic                       fpu_gnt_i;

    // FPU result channel (never backpressured)
    logic                       fpu_rvalid_i;
    logic [DATA_WIDTH-1:0]      fpu_rdata_i;
    logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i;
    logic [ID_WIDTH-1:0]        fpu_rID_i;

    // Buffered response channel
    logic                       resp_valid_o;
    logic                       resp_ready_i;
    logic [DATA_WIDTH-1:0]      resp_data_o;
    logic [FLAGS_OUT_WIDTH-1:0] resp_flags_o;
    logic [ID_WIDTH-1:0]        resp_ID_o;

    // Status
    logic [CNT_W-1:0]           credits_o;
    logic                       idle_o;
    logic                       overflow_o;

    // Surroundings: interconnect, FPU wrapper and response consumer
    modport master (
        output req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
               fpu_rID_i, resp_ready_i,
        input  gnt_o, fpu_req_o, resp_valid_o, resp_data_o, resp_flags_o,
               resp_ID_o, credits_o, idle_o, overflow_o
    );

    // The response buffer itself
    modport slave (
        input  req_i, fpu_gnt_i, fpu_rvalid_i, fpu_rdata_i, fpu_rflags_i,
               fpu_rID_i, resp_ready_i,
        output gnt_o, fpu_req_o, resp_valid_o, resp_data_o, resp_flags_o,
               resp_ID_o, credits_o, idle_o, overflow_o
    );
endinterface

// File: rtl/fpu_resp_buffer.sv
// Credit-gated response buffer behind the shared FPU wrapper. Every FPU
// result is captured in a small FIFO and re-presented with a valid/ready
// handshake; requests are only granted while a free slot is guaranteed.
module fpu_resp_buffer #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4
) (
    input logic              clk,
    input logic              rst,
    fpu_resp_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [CNT_W-1:0]           credits_q, credits_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic                       overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]      mem_data_q  [DEPTH];
    logic [DATA_WIDTH-1:0]      mem_data_d  [DEPTH];
    logic [FLAGS_OUT_WIDTH-1:0] mem_flags_q [DEPTH];
    logic [FLAGS_OUT_WIDTH-1:0] mem_flags_d [DEPTH];
    logic [ID_WIDTH-1:0]        mem_id_q    [DEPTH];
    logic [ID_WIDTH-1:0]        mem_id_d    [DEPTH];

    logic avail;
    logic issue;
    logic pop;
    logic push;
    logic full;
    logic wr_en;

    // Handshake gating depends only on registered credits, so neither
    // resp_ready_i nor fpu_rvalid_i reaches the grant combinationally.
    assign avail = (credits_q != '0);
    assign issue = bus.req_i & avail & bus.fpu_gnt_i;
    assign pop   = (count_q != '0) & bus.resp_ready_i;
    assign push  = bus.fpu_rvalid_i;
    assign full  = (count_q == CNT_DEPTH);
    // A full FIFO can still accept a result when the head leaves this cycle.
    assign wr_en = push & (~full | pop);

    // Credit bookkeeping: taken at issue, returned when the result is popped.
    always_comb begin
        credits_d = credits_q;
        if (issue && !pop) begin
            credits_d = credits_q - CNT_ONE;
        end else if (pop && !issue && credits_q != CNT_DEPTH) begin
            credits_d = credits_q + CNT_ONE;
        end
    end

    // FIFO next state: write at wr_ptr, read at rd_ptr, sticky overflow on drop.
    always_comb begin
        mem_data_d  = mem_data_q;
        mem_flags_d = mem_flags_q;
        mem_id_d    = mem_id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        if (wr_en) begin
            mem_data_d[wr_ptr_q]  = bus.fpu_rdata_i;
            mem_flags_d[wr_ptr_q] = bus.fpu_rflags_i;
            mem_id_d[wr_ptr_q]    = bus.fpu_rID_i;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !wr_en) begin
            count_d = count_q - CNT_ONE;
        end
        if (push && !wr_en) begin
            overflow_d = 1'b1;
        end
    end

    // State registers; storage also clears so the head reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q  <= CNT_DEPTH;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i]  <= '0;
                mem_flags_q[i] <= '0;
                mem_id_q[i]    <= '0;
            end
        end else begin
            credits_q   <= credits_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            mem_data_q  <= mem_data_d;
            mem_flags_q <= mem_flags_d;
            mem_id_q    <= mem_id_d;
        end
    end

    assign bus.fpu_req_o    = bus.req_i & avail;
    assign bus.gnt_o        = bus.fpu_gnt_i & avail;
    assign bus.resp_valid_o = (count_q != '0);
    assign bus.resp_data_o  = mem_data_q[rd_ptr_q];
    assign bus.resp_flags_o = mem_flags_q[rd_ptr_q];
    assign bus.resp_ID_o    = mem_id_q[rd_ptr_q];
    assign bus.credits_o    = credits_q;
    assign bus.idle_o       = (credits_q == CNT_DEPTH);
    assign bus.overflow_o   = overflow_q;
endmodule

// File: tb/tb_fpu_resp_buffer.sv
// Directed bench for fpu_resp_buffer: credits, ordering, wrap, overflow, reset.
module tb_fpu_resp_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fpu_resp_buffer_if #(.ID_WIDTH(9), .DATA_WIDTH(32), .FLAGS_OUT_WIDTH(5), .DEPTH(4)) bus ();

    fpu_resp_buffer #(.ID_WIDTH(9), .DATA_WIDTH(32), .FLAGS_OUT_WIDTH(5), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_ops(input int n);
        bus.req_i     = 1'b1;
        bus.fpu_gnt_i = 1'b1;
        repeat (n) cycle();
        bus.req_i     = 1'b0;
        bus.fpu_gnt_i = 1'b0;
    endtask

    task automatic push_result(input int id, input logic [31:0] data);
        bus.fpu_rvalid_i = 1'b1;
        bus.fpu_rID_i    = 9'(id);
        bus.fpu_rdata_i  = data;
        bus.fpu_rflags_i = 5'(id);
        cycle();
        bus.fpu_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_i = 0; bus.fpu_gnt_i = 0; bus.fpu_rvalid_i = 0;
        bus.fpu_rdata_i = '0; bus.fpu_rflags_i = '0; bus.fpu_rID_i = '0;
        bus.resp_ready_i = 0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        tests++; if (bus.gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0", bus.gnt_o); end
        tests++; if (bus.fpu_req_o !== 1'b0) begin fails++; $display("FAIL reset_fpu_req: got %b want 0", bus.fpu_req_o); end
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid_o); end
        tests++; if (bus.resp_data_o !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.resp_data_o); end
        tests++; if (bus.resp_ID_o !== 9'h0 || bus.resp_flags_o !== 5'h0) begin fails++; $display("FAIL reset_id_flags: got %h/%h want 0/0", bus.resp_ID_o, bus.resp_flags_o); end
        tests++; if (bus.credits_o !== 3'd4) begin fails++; $display("FAIL reset_credits: got %0d want 4", bus.credits_o); end
        tests++; if (bus.idle_o !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b want 1", bus.idle_o); end
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", bus.overflow_o); end
    endtask

    task automatic test_single_op();
        bus.req_i = 1; bus.fpu_gnt_i = 1;
        #1;
        tests++; if (bus.fpu_req_o !== 1'b1 || bus.gnt_o !== 1'b1) begin fails++; $display("FAIL single_grant: got req=%b gnt=%b want 1/1", bus.fpu_req_o, bus.gnt_o); end
        cycle();
        bus.req_i = 0; bus.fpu_gnt_i = 0;
        #1;
        tests++; if (bus.credits_o !== 3'd3) begin fails++; $display("FAIL single_credits_taken: got %0d want 3", bus.credits_o); end
        tests++; if (bus.idle_o !== 1'b0) begin fails++; $display("FAIL single_not_idle: got %b want 0", bus.idle_o); end
        bus.fpu_rvalid_i = 1; bus.fpu_rdata_i = 32'h3F80_0000; bus.fpu_rID_i = 9'd5; bus.fpu_rflags_i = 5'h10;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL single_no_bypass: got %b want 0", bus.resp_valid_o); end
        cycle();
        bus.fpu_rvalid_i = 0;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", bus.resp_valid_o); end
        tests++; if (bus.resp_data_o !== 32'h3F80_0000) begin fails++; $display("FAIL single_data: got %h want 3f800000", bus.resp_data_o); end
        tests++; if (bus.resp_ID_o !== 9'd5 || bus.resp_flags_o !== 5'h10) begin fails++; $display("FAIL single_id_flags: got %0d/%h want 5/10", bus.resp_ID_o, bus.resp_flags_o); end
        bus.resp_ready_i = 1;
        cycle();
        bus.resp_ready_i = 0;
        #1;
        tests++; if (bus.credits_o !== 3'd4 || bus.idle_o !== 1'b1) begin fails++; $display("FAIL single_credit_back: got %0d idle=%b want 4 idle=1", bus.credits_o, bus.idle_o); end
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL single_empty: got %b want 0", bus.resp_valid_o); end
    endtask

    task automatic test_credit_exhaust();
        bus.resp_ready_i = 0;
        issue_ops(4);
        #1;
        tests++; if (bus.credits_o !== 3'd0) begin fails++; $display("FAIL exhaust_credits: got %0d want 0", bus.credits_o); end
        bus.req_i = 1; bus.fpu_gnt_i = 1;
        #1;
        tests++; if (bus.fpu_req_o !== 1'b0 || bus.gnt_o !== 1'b0) begin fails++; $display("FAIL exhaust_blocked: got req=%b gnt=%b want 0/0", bus.fpu_req_o, bus.gnt_o); end
        for (int i = 0; i < 4; i++) push_result(10 + i, 32'h1000 + i);
        #1;
        tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_ID_o !== 9'd10) begin fails++; $display("FAIL exhaust_head: got v=%b id=%0d want 1/10", bus.resp_valid_o, bus.resp_ID_o); end
        bus.resp_ready_i = 1;
        #1;
        tests++; if (bus.gnt_o !== 1'b0) begin fails++; $display("FAIL exhaust_no_comb_path: got gnt=%b want 0", bus.gnt_o); end
        cycle();
        bus.resp_ready_i = 0;
        #1;
        tests++; if (bus.gnt_o !== 1'b1 || bus.fpu_req_o !== 1'b1) begin fails++; $display("FAIL exhaust_regrant: got gnt=%b req=%b want 1/1", bus.gnt_o, bus.fpu_req_o); end
        bus.req_i = 0; bus.fpu_gnt_i = 0;
        bus.resp_ready_i = 1;
        for (int i = 1; i < 4; i++) begin
            #1;
            tests++; if (bus.resp_ID_o !== 9'(10 + i)) begin fails++; $display("FAIL exhaust_order: got %0d want %0d", bus.resp_ID_o, 10 + i); end
            cycle();
        end
        bus.resp_ready_i = 0;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b0 || bus.credits_o !== 3'd4) begin fails++; $display("FAIL exhaust_drained: got v=%b cr=%0d want 0/4", bus.resp_valid_o, bus.credits_o); end
    endtask

    task automatic test_full_push_pop();
        issue_ops(4);
        for (int i = 20; i < 24; i++) push_result(i, 32'h2000 + i);
        #1;
        tests++; if (bus.resp_ID_o !== 9'd20 || bus.credits_o !== 3'd0) begin fails++; $display("FAIL full_setup: got id=%0d cr=%0d want 20/0", bus.resp_ID_o, bus.credits_o); end
        bus.fpu_rvalid_i = 1; bus.fpu_rID_i = 9'd24; bus.fpu_rdata_i = 32'h2000 + 24; bus.fpu_rflags_i = 5'd24;
        bus.resp_ready_i = 1;
        cycle();
        bus.fpu_rvalid_i = 0;
        #1;
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL full_pp_overflow: got %b want 0", bus.overflow_o); end
        tests++; if (bus.credits_o !== 3'd1) begin fails++; $display("FAIL full_pp_credits: got %0d want 1", bus.credits_o); end
        for (int i = 21; i < 25; i++) begin
            #1;
            tests++; if (bus.resp_valid_o !== 1'b1 || bus.resp_ID_o !== 9'(i) || bus.resp_data_o !== 32'h2000 + i) begin fails++; $display("FAIL full_pp_order: got v=%b id=%0d d=%h want 1/%0d/%h", bus.resp_valid_o, bus.resp_ID_o, bus.resp_data_o, i, 32'h2000 + i); end
            cycle();
        end
        bus.resp_ready_i = 0;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL full_pp_count: got v=%b want 0", bus.resp_valid_o); end
        tests++; if (bus.credits_o !== 3'd4 || bus.idle_o !== 1'b1) begin fails++; $display("FAIL full_pp_saturate: got %0d want 4", bus.credits_o); end
    endtask

    task automatic test_wrap();
        int exp_id = 0;
        bus.resp_ready_i = 1;
        for (int c = 0; c < 13; c++) begin
            bus.req_i     = (c < 10);
            bus.fpu_gnt_i = (c < 10);
            bus.fpu_rvalid_i = (c >= 1 && c <= 10);
            bus.fpu_rID_i    = 9'(c - 1);
            bus.fpu_rdata_i  = 32'hA000 + c - 1;
            bus.fpu_rflags_i = 5'(c - 1);
            #1;
            if (c < 10) begin
                tests++; if (bus.fpu_req_o !== 1'b1) begin fails++; $display("FAIL wrap_issue: cycle %0d got %b want 1", c, bus.fpu_req_o); end
            end
            if (bus.resp_valid_o === 1'b1) begin
                tests++; if (bus.resp_ID_o !== 9'(exp_id) || bus.resp_data_o !== 32'hA000 + exp_id) begin fails++; $display("FAIL wrap_order: got id=%0d d=%h want %0d/%h", bus.resp_ID_o, bus.resp_data_o, exp_id, 32'hA000 + exp_id); end
                exp_id++;
            end
            cycle();
        end
        bus.req_i = 0; bus.fpu_gnt_i = 0; bus.fpu_rvalid_i = 0; bus.resp_ready_i = 0;
        #1;
        tests++; if (exp_id != 10) begin fails++; $display("FAIL wrap_count: got %0d responses want 10", exp_id); end
        tests++; if (bus.credits_o !== 3'd4 || bus.resp_valid_o !== 1'b0 || bus.overflow_o !== 1'b0) begin fails++; $display("FAIL wrap_end: got cr=%0d v=%b ovf=%b want 4/0/0", bus.credits_o, bus.resp_valid_o, bus.overflow_o); end
    endtask

    task automatic test_overflow();
        issue_ops(4);
        for (int i = 30; i < 34; i++) push_result(i, 32'h3000 + i);
        push_result(34, 32'hDEAD);
        #1;
        tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", bus.overflow_o); end
        tests++; if (bus.resp_ID_o !== 9'd30 || bus.resp_data_o !== 32'h3000 + 30) begin fails++; $display("FAIL ovf_head: got id=%0d d=%h want 30/301e", bus.resp_ID_o, bus.resp_data_o); end
        cycle();
        tests++; if (bus.overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow_o); end
        bus.resp_ready_i = 1;
        for (int i = 30; i < 34; i++) begin
            #1;
            tests++; if (bus.resp_ID_o !== 9'(i) || bus.resp_data_o !== 32'h3000 + i) begin fails++; $display("FAIL ovf_contents: got id=%0d d=%h want %0d/%h", bus.resp_ID_o, bus.resp_data_o, i, 32'h3000 + i); end
            cycle();
        end
        bus.resp_ready_i = 0;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b0 || bus.overflow_o !== 1'b1 || bus.credits_o !== 3'd4) begin fails++; $display("FAIL ovf_drained: got v=%b ovf=%b cr=%0d want 0/1/4", bus.resp_valid_o, bus.overflow_o, bus.credits_o); end
    endtask

    task automatic test_reset_mid();
        issue_ops(3);
        for (int i = 40; i < 43; i++) push_result(i, 32'hC0DE_0000 + i);
        #1;
        tests++; if (bus.resp_valid_o !== 1'b1 || bus.credits_o !== 3'd1) begin fails++; $display("FAIL rstmid_setup: got v=%b cr=%0d want 1/1", bus.resp_valid_o, bus.credits_o); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        tests++; if (bus.resp_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", bus.resp_valid_o); end
        tests++; if (bus.credits_o !== 3'd4 || bus.idle_o !== 1'b1) begin fails++; $display("FAIL rstmid_credits: got %0d idle=%b want 4/1", bus.credits_o, bus.idle_o); end
        tests++; if (bus.overflow_o !== 1'b0) begin fails++; $display("FAIL rstmid_overflow: got %b want 0", bus.overflow_o); end
        tests++; if (bus.resp_data_o !== 32'h0 || bus.resp_ID_o !== 9'h0) begin fails++; $display("FAIL rstmid_data: got d=%h id=%0d want 0/0", bus.resp_data_o, bus.resp_ID_o); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_credit_exhaust();
        test_full_push_pop();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
